phase_nco: RTL
==============

# phase_nco

Numerically controlled oscillator front end that generates the phase word driving the sine lookup ROM and collects the ROM's registered sample back into a valid/ready output stream. A phase accumulator advances by a configurable frequency control word (FCW) on each sample-rate tick. A static phase offset is added before the phase is presented to the ROM. The block sits between the audio/control configuration path and the downstream sample consumer (mixer/DAC serializer) and owns all sample pacing and backpressure for the sine path.

## Interface
- PHASE_WIDTH, 32, width of accumulator, FCW, offset and phase output
- SAMPLE_WIDTH, 16, width of signed sample returned by ROM and output stream
- DROP_CNT_WIDTH, 16, width of saturating dropped-tick counter
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  sample-rate strobe, one-cycle pulse per requested sample
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  configuration accept (combinational)
- cfg_fcw  input  PHASE_WIDTH  frequency control word (unsigned)
- cfg_phase_off  input  PHASE_WIDTH  phase offset (unsigned, modulo 2^PHASE_WIDTH)
- cfg_phase_reset  input  1  clear accumulator on config accept
- phase  output  PHASE_WIDTH  registered phase to ROM address input
- rom_sample  input  signed SAMPLE_WIDTH  ROM output, valid 1 cycle after phase changes
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accept
- out_sample  output  signed SAMPLE_WIDTH  registered output sample
- overrun  output  1  sticky: at least one tick dropped since last config accept
- drop_count  output  DROP_CNT_WIDTH  saturating count of dropped ticks

## Operation
- States: IDLE (after reset, no config yet) and RUN. The first accepted config moves IDLE -> RUN. There is no path back except rst.
- Registers: acc, fcw, off, phase, in-flight flags s1/s2, out_sample, out_valid, overrun, drop_count.
- Config handshake:
  - cfg_ready = (state==IDLE) || (!s1 && !s2).
  - On cfg_valid && cfg_ready: fcw <= cfg_fcw; off <= cfg_phase_off; acc <= cfg_phase_reset ? 0 : acc; overrun <= 0. drop_count is not cleared.
  - A pending output sample is unaffected by config.
- Tick accept:
  - Condition: state==RUN && !s1 && !s2 && (!out_valid || out_ready) && !(cfg_valid && cfg_ready).
  - On accept: phase <= acc + off; acc <= acc + fcw; s1 <= 1. Both sums are mod 2^PHASE_WIDTH and wrap silently.
- Pipeline:
  - s1 -> s2 on the next edge, which is when the ROM registers its output.
  - When s2 is set, the next edge performs out_sample <= rom_sample; out_valid <= 1; s2 <= 0.
- Output handshake:
  - out_valid && out_ready clears out_valid on that edge. out_sample holds until the next capture.
  - out_sample and out_valid are stable while out_valid && !out_ready.
- Drop:
  - A tick in RUN that is not accepted, for any reason (in flight, backpressure, or simultaneous config), sets overrun <= 1 and increments drop_count, saturating at all-ones.
  - Ticks in IDLE are ignored and not counted.
  - When a config accept and a dropped tick occur on the same edge, overrun ends at 1 (the drop is recorded after the clear).
- phase holds its last value between ticks.

## Timing
- Reset values: phase 0, out_sample 0, out_valid 0, overrun 0, drop_count 0, state IDLE, acc/fcw/off 0, s1/s2 0. cfg_ready is 1 in IDLE.
- Latency for a tick accepted at edge E0:
  - phase updates after E0.
  - rom_sample is valid after E1.
  - out_valid asserts after E2, i.e. 3 cycles from the tick cycle to the out_valid cycle.
- Throughput: at most one sample per 3 cycles. Ticks must be spaced ≥3 cycles; otherwise they drop.
- rst mid-flight: all in-flight flags and out_valid clear on the reset edge. No sample from before reset ever appears.
- cfg_ready deasserts for exactly the 2 cycles s1/s2 are busy (RUN only).

## Test plan
- Reset, then cfg fcw=0x40000000, off=0, phase_reset=1; 5 ticks spaced 4 cycles, out_ready=1 -> phase sequence 0x00000000, 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (wrap); each out_sample equals ROM[phase[31:24]] exactly 3 cycles after its tick.
- cfg off=0x80000000, fcw=0, phase_reset=1; 2 ticks -> phase=0x80000000 both times; out_sample = ROM[0x80] twice.
- Backpressure: out_ready=0, ticks at cycles 0, 4, 8 -> first sample held stable with out_valid=1; ticks 2 and 3 dropped, drop_count=2, overrun=1. Then out_ready=1 -> single transfer, then next tick accepted.
- Tick 1 cycle after an accepted tick -> dropped; drop_count +1; cfg_ready=0 for 2 cycles; accepted tick's sample still correct.
- Simultaneous cfg_valid and tick in RUN -> config applied, tick dropped, overrun=1 after edge. Saturation: 70000 dropped ticks with DROP_CNT_WIDTH=16 -> drop_count=0xFFFF.
- Assert rst 1 cycle after tick accept -> out_valid never asserts, phase=0, state IDLE; subsequent ticks ignored until cfg accepted.

Source files
------------

// File: rtl/phase_nco.sv
// phase_nco: phase accumulator NCO front end with ROM sample capture, valid/ready output and drop tracking
module phase_nco #(
    parameter int PHASE_WIDTH    = 32,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic        [PHASE_WIDTH-1:0]    cfg_fcw,
    input  logic        [PHASE_WIDTH-1:0]    cfg_phase_off,
    input  logic                             cfg_phase_reset,
    output logic        [PHASE_WIDTH-1:0]    phase,
    input  logic signed [SAMPLE_WIDTH-1:0]   rom_sample,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [SAMPLE_WIDTH-1:0]   out_sample,
    output logic                             overrun,
    output logic        [DROP_CNT_WIDTH-1:0] drop_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [PHASE_WIDTH-1:0] acc, fcw, off;
    logic s1, s2, busy, cfg_acc, tick_acc, drop;
    // handshake decode: config wins over a same-cycle tick, which then counts as dropped
    always_comb begin
        busy      = s1 || s2;
        cfg_ready = (state == IDLE) || !busy;
        cfg_acc   = cfg_valid && cfg_ready;
        tick_acc  = tick && (state == RUN) && !busy && (!out_valid || out_ready) && !cfg_acc;
        drop      = tick && (state == RUN) && !tick_acc;
        state_nxt = cfg_acc ? RUN : state;
    end
    // state register: first accepted config enters RUN for good
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // configuration and phase accumulation, both sums wrap modulo 2^PHASE_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            fcw   <= '0;
            off   <= '0;
            phase <= '0;
        end else if (cfg_acc) begin
            fcw <= cfg_fcw;
            off <= cfg_phase_off;
            acc <= cfg_phase_reset ? '0 : acc;
        end else if (tick_acc) begin
            phase <= acc + off;
            acc   <= acc + fcw;
        end
    end
    // in-flight tracking and output capture two edges after the accepted tick
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            s1 <= tick_acc;
            s2 <= s1;
            if (s2) begin
                out_sample <= rom_sample;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
    // drop bookkeeping: a drop on a config edge still leaves overrun set
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop)         overrun <= 1'b1;
            else if (cfg_acc) overrun <= 1'b0;
            if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end
endmodule
